exec_control: RTL and testbench

EXEC_CONTROL -- requirements
Module: exec_control

---
 rtl/exec_ctrl_pkg.sv | 14 +
 rtl/sat_counter.sv | 22 ++
 rtl/exec_control.sv | 115 +++++++++++
 tb/tb_exec_control.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution controller: FSM encodings and default widths.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam int DEF_MSB   = 11;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/exec_control.sv
// Run/step/halt controller for a small CPU program counter.
// Optional cycle counter enabled by defining EXEC_CYCLE_COUNT_EN.
module exec_control
    import exec_ctrl_pkg::*;
#(
    parameter int MSB   = DEF_MSB,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic             i_halt_op,
    input  logic [MSB-1:0]   i_pc,
    output logic             o_pc_en,
    output logic             o_pc_clr,
    output logic             o_halted,
    output logic             o_done,
    output logic             o_busy,
    output logic [MSB-1:0]   o_halt_pc,
    output logic [CNT_W-1:0] o_cycles,
    output logic [1:0]       o_state
);

    state_t         state;
    state_t         state_next;
    logic           step_armed;
    logic           pc_clr_q;
    logic           done_q;
    logic [MSB-1:0] halt_pc_q;
    logic           halt_load;
    logic           pc_en;

    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        halt_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_RUN;
                end else if (i_step && step_armed) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_halt_op) begin
                    state_next = ST_HALT;
                end
            end
            ST_STEP: begin
                state_next = i_halt_op ? ST_HALT : ST_IDLE;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (i_clear) begin
            state_next = ST_IDLE;
        end
        pc_en     = ((state == ST_RUN) || (state == ST_STEP)) && !i_halt_op && !pc_clr_q;
        halt_load = ((state == ST_RUN) || (state == ST_STEP)) && (state_next == ST_HALT);
    end

    // step_armed makes STEP edge-qualified: a held i_step fires once, then must drop in IDLE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            step_armed <= 1'b1;
            pc_clr_q   <= 1'b0;
            done_q     <= 1'b0;
            halt_pc_q  <= '0;
        end else begin
            state    <= state_next;
            pc_clr_q <= i_clear;
            done_q   <= halt_load;
            if (halt_load) begin
                halt_pc_q <= i_pc;
            end
            if ((state == ST_IDLE) && (state_next == ST_STEP)) begin
                step_armed <= 1'b0;
            end else if ((state == ST_IDLE) && !i_step) begin
                step_armed <= 1'b1;
            end
        end
    end

    assign o_pc_en   = pc_en;
    assign o_pc_clr  = pc_clr_q;
    assign o_done    = done_q;
    assign o_halted  = (state == ST_HALT);
    assign o_busy    = (state == ST_RUN) || (state == ST_STEP);
    assign o_halt_pc = halt_pc_q;
    assign o_state   = state;

`ifdef EXEC_CYCLE_COUNT_EN
    // Clearing on the sampled i_clear makes the count read 0 in the o_pc_clr cycle.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycles (
        .clk   (i_clk),
        .rst_n (i_rst),
        .inc   (pc_en),
        .clr   (i_clear),
        .count (o_cycles)
    );
`else
    assign o_cycles = '0;
`endif

endmodule

// File: tb/tb_exec_control.sv
// Directed bench for exec_control with a scoreboard on o_done / o_pc_clr events.
module tb_exec_control;

    localparam int MSB   = 11;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             step;
    logic             clear;
    logic             halt_op;
    logic [MSB-1:0]   pc;
    logic             pc_en;
    logic             pc_clr;
    logic             halted;
    logic             done;
    logic             busy;
    logic [MSB-1:0]   halt_pc;
    logic [CNT_W-1:0] cycles;
    logic [1:0]       state;

    logic [15:0] done_q[$];
    logic [15:0] clr_q[$];

    int checks;
    int errors;
    int pc_en_cnt;

    exec_control #(
        .MSB   (MSB),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_step    (step),
        .i_clear   (clear),
        .i_halt_op (halt_op),
        .i_pc      (pc),
        .o_pc_en   (pc_en),
        .o_pc_clr  (pc_clr),
        .o_halted  (halted),
        .o_done    (done),
        .o_busy    (busy),
        .o_halt_pc (halt_pc),
        .o_cycles  (cycles),
        .o_state   (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] exp_cyc(int n);
        int lim;
        lim = 0;
`ifdef EXEC_CYCLE_COUNT_EN
        lim = 15;
`endif
        return (n > lim) ? 4'(lim) : 4'(n);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (pc_en === 1'b1) pc_en_cnt++;
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got pulse expected none");
            end else begin
                check("done_event", {1'b0, halt_pc, cycles}, done_q.pop_front());
            end
        end
        if (pc_clr === 1'b1) begin
            if (clr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pc_clr_unexpected: got pulse expected none");
            end else begin
                check("pc_clr_event", {8'd0, state, pc_en, halted, cycles}, clr_q.pop_front());
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        pc_en_cnt = 0;
        rst       = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        clear     = 1'b0;
        halt_op   = 1'b0;
        pc        = '0;

        // reset state
        tick(2);
        check("rst_state", state, 2'b00);
        check("rst_flags", {busy, halted, done, pc_clr, pc_en}, 5'b0);
        check("rst_halt_pc", halt_pc, 11'd0);
        check("rst_cycles", cycles, 4'd0);
        rst = 1'b1;
        tick(1);

        // RUN for 5 enabled cycles, then HALT at pc 5
        pc_en_cnt = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("run_entry", {busy, state}, {1'b1, 2'b01});
        tick(5);
        done_q.push_back({1'b0, 11'd5, exp_cyc(5)});
        halt_op = 1'b1;
        pc      = 11'd5;
        tick(1);
        halt_op = 1'b0;
        pc      = 11'd9;
        tick(2);
        check("run_pc_en_cycles", pc_en_cnt, 5);
        check("run_halted", {halted, busy, state}, {1'b1, 1'b0, 2'b11});

        // HALT ignores start; clear exits
        start = 1'b1;
        tick(2);
        check("halt_ignores_start", {halted, state}, {1'b1, 2'b11});
        check("halt_no_pc_en", pc_en_cnt, 5);
        clr_q.push_back({8'd0, 2'b00, 1'b0, 1'b0, 4'd0});
        start = 1'b0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        check("halt_exit_idle", {halted, state}, {1'b0, 2'b00});
        check("halt_pc_hold", halt_pc, 11'd5);

        // held step executes exactly one instruction
        pc_en_cnt = 0;
        step = 1'b1;
        tick(4);
        step = 1'b0;
        check("step_one_pc_en", pc_en_cnt, 1);
        check("step_back_idle", state, 2'b00);
        check("step_cycles", cycles, exp_cyc(1));
        tick(1);

        // step onto a HALT instruction
        step = 1'b1;
        tick(1);
        step    = 1'b0;
        halt_op = 1'b1;
        pc      = 11'h7A3;
        done_q.push_back({1'b0, 11'h7A3, exp_cyc(1)});
        tick(1);
        halt_op = 1'b0;
        tick(1);
        check("step_halt_state", state, 2'b11);
        clr_q.push_back({8'd0, 2'b00, 1'b0, 1'b0, 4'd0});
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);

        // start, step and clear together in IDLE
        pc_en_cnt = 0;
        clr_q.push_back({8'd0, 2'b00, 1'b0, 1'b0, 4'd0});
        start = 1'b1;
        step  = 1'b1;
        clear = 1'b1;
        tick(1);
        start = 1'b0;
        step  = 1'b0;
        clear = 1'b0;
        tick(2);
        check("simul_idle", state, 2'b00);
        check("simul_no_pc_en", pc_en_cnt, 0);

        // saturation with a 4-bit counter
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            check($sformatf("sat_cycles_%0d", i), cycles, exp_cyc(i));
        end

        // asynchronous reset mid-RUN
        rst = 1'b0;
        #1;
        check("midrun_rst_busy", {busy, state}, {1'b0, 2'b00});
        check("midrun_rst_cycles", cycles, 4'd0);
        check("midrun_rst_halt_pc", halt_pc, 11'd0);
        tick(1);
        rst   = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("post_rst_run", state, 2'b01);
        clr_q.push_back({8'd0, 2'b00, 1'b0, 1'b0, 4'd0});
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(2);
        check("final_idle", state, 2'b00);

        check("done_q_drained", done_q.size(), 0);
        check("clr_q_drained", clr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
